// File: rtl/rgbw_pwm_array_if.sv
// rtl/rgbw_pwm_array_if.sv - control, duty and output bundle for rgbw_pwm_array
// Signals:
//   clk_en        tick enable from the clock prescaler
//   run           1 = generate, 0 = counter held at 0 and outputs low
//   duty_in       packed duties, channel i at [i*WIDTH +: WIDTH]
//   duty_ld       single-cycle strobe capturing duty_in into the pending buffer
//   duty_pending  pending buffer holds a value not yet applied
//   period_tick   one-clock pulse on the wrap edge
//   pwm_out       registered PWM outputs
// Modports: master drives controls and duties, slave is the PWM block.
interface rgbw_pwm_array_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  logic                      clk_en;
  logic                      run;
  logic [CHANNELS*WIDTH-1:0] duty_in;
  logic                      duty_ld;
  logic                      duty_pending;
  logic                      period_tick;
  logic [CHANNELS-1:0]       pwm_out;

  modport master (
    output clk_en, run, duty_in, duty_ld,
    input  duty_pending, period_tick, pwm_out
  );

  modport slave (
    input  clk_en, run, duty_in, duty_ld,
    output duty_pending, period_tick, pwm_out
  );
endinterface

// File: rtl/rgbw_pwm_array.sv
// rtl/rgbw_pwm_array.sv - multi-channel double-buffered PWM generator with optional phase stagger
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    rgbw_pwm_array_if.slave
//          in : clk_en, run, duty_in, duty_ld
//          out: duty_pending, period_tick, pwm_out
module rgbw_pwm_array #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int STAGGER  = 1
) (
  input  logic            clk,
  input  logic            reset,
  rgbw_pwm_array_if.slave bus
);
  localparam int PERIOD = 1 << WIDTH;
  // Turn-on offset between neighbouring channels; 0 keeps all edges aligned.
  localparam int OFF = (STAGGER != 0) ? PERIOD / CHANNELS : 0;

  logic [WIDTH-1:0]    cnt;
  logic [WIDTH-1:0]    pending [CHANNELS];
  logic [WIDTH-1:0]    active  [CHANNELS];
  logic [WIDTH-1:0]    phase   [CHANNELS];
  logic                pend_flag;
  logic [CHANNELS-1:0] pwm_q;
  logic                tick_q;
  logic                step;
  logic                wrap;

  assign step = bus.clk_en & bus.run;
  assign wrap = step & (cnt == {WIDTH{1'b1}});

  // Phase addition wraps naturally in WIDTH bits, giving mod 2^WIDTH.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      phase[i] = cnt + WIDTH'(i * OFF);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      pend_flag <= 1'b0;
      pwm_q     <= '0;
      tick_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      if (!bus.run) begin
        cnt    <= '0;
        pwm_q  <= '0;
        tick_q <= 1'b0;
      end else if (bus.clk_en) begin
        cnt    <= cnt + 1'b1;
        tick_q <= wrap;
        // Compare uses the pre-increment count and pre-update duty.
        for (int i = 0; i < CHANNELS; i++) begin
          pwm_q[i] <= (phase[i] < active[i]);
        end
      end else begin
        tick_q <= 1'b0;
      end

      // Wrap transfers the pending contents as they were before this edge,
      // so a coincident load lands in pending and waits for the next wrap.
      if (wrap && pend_flag) begin
        for (int i = 0; i < CHANNELS; i++) begin
          active[i] <= pending[i];
        end
      end

      if (bus.duty_ld) begin
        for (int i = 0; i < CHANNELS; i++) begin
          pending[i] <= bus.duty_in[i*WIDTH +: WIDTH];
        end
        pend_flag <= 1'b1;
      end else if (wrap) begin
        pend_flag <= 1'b0;
      end
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_tick  = tick_q;
  assign bus.duty_pending = pend_flag;
endmodule
